// File: rtl/wb_daq_channel_arbiter.sv
// Round-robin DAQ sample mover: grants one of four channels at a time and stores
// each accepted sample as a single 32-bit Wishbone classic write into that channel's buffer.
module wb_daq_channel_arbiter #(
  parameter int dw = 32,
  parameter int aw = 32
) (
  input  logic            wb_clk,
  input  logic            wb_rst,
  input  logic [dw-1:0]   daq_control_reg,
  input  logic [4*dw-1:0] ch_address_i,
  input  logic [4*dw-1:0] ch_control_i,
  output logic [4*dw-1:0] ch_status_o,
  input  logic [3:0]      ch_valid_i,
  input  logic [4*dw-1:0] ch_data_i,
  output logic [3:0]      ch_ready_o,
  output logic [aw-1:0]   wbm_adr_o,
  output logic [dw-1:0]   wbm_dat_o,
  output logic [3:0]      wbm_sel_o,
  output logic            wbm_we_o,
  output logic            wbm_cyc_o,
  output logic            wbm_stb_o,
  output logic [2:0]      wbm_cti_o,
  output logic [1:0]      wbm_bte_o,
  input  logic            wbm_ack_i,
  input  logic            wbm_err_i,
  output logic            interrupt
);

  typedef enum logic [1:0] {IDLE, ARB, WRITE} state_t;

  state_t      state, state_nxt;
  logic        daq_en;
  logic [3:0]  en, wrap, irq_en, eligible, busy;
  logic [15:0] length    [4];
  logic [15:0] count     [4];
  logic [15:0] count_inc [4];
  logic [3:0]  full, wrapped, error, clr_pend;
  logic [1:0]  last_grant, grant, pick;
  logic        found, term;
  logic        unused_cfg;

  assign daq_en    = daq_control_reg[0];
  assign term      = (state == WRITE) && (wbm_ack_i || wbm_err_i);
  assign wbm_cti_o = 3'b000;
  assign wbm_bte_o = 2'b00;

  assign unused_cfg = ^{daq_control_reg[dw-1:1],
                        ch_control_i[3*dw+3 +: 13], ch_control_i[2*dw+3 +: 13],
                        ch_control_i[dw+3 +: 13], ch_control_i[3 +: 13]};

  always_comb begin
    for (int n = 0; n < 4; n++) begin
      en[n]        = ch_control_i[n*dw];
      wrap[n]      = ch_control_i[n*dw+1];
      irq_en[n]    = ch_control_i[n*dw+2];
      length[n]    = ch_control_i[n*dw+16 +: 16];
      count_inc[n] = count[n] + 16'd1;
      busy[n]      = (state == WRITE) && (grant == 2'(n));
      eligible[n]  = daq_en && en[n] && ch_valid_i[n] && !full[n] && !error[n]
                     && (length[n] != 16'd0);
      ch_status_o[n*dw +: dw] = dw'({busy[n], error[n], wrapped[n], full[n], count[n]});
    end
  end

  // Search starts one past the last grant; offset 4 wraps back onto last_grant itself.
  always_comb begin
    found = 1'b0;
    pick  = last_grant;
    for (int i = 1; i <= 4; i++) begin
      if (!found && eligible[last_grant + 2'(i)]) begin
        found = 1'b1;
        pick  = last_grant + 2'(i);
      end
    end
  end

  always_ff @(posedge wb_clk) begin
    if (!wb_rst) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (daq_en) state_nxt = ARB;
      ARB: begin
        if (found)        state_nxt = WRITE;
        else if (!daq_en) state_nxt = IDLE;
      end
      WRITE:   if (wbm_ack_i || wbm_err_i) state_nxt = ARB;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant and bus launch: address and sample are captured at the grant edge so the
  // master outputs stay constant through any number of wait states.
  always_ff @(posedge wb_clk) begin
    if (!wb_rst) begin
      last_grant <= 2'd3;
      grant      <= 2'd0;
      ch_ready_o <= '0;
      wbm_adr_o  <= '0;
      wbm_dat_o  <= '0;
      wbm_sel_o  <= '0;
      wbm_we_o   <= 1'b0;
      wbm_cyc_o  <= 1'b0;
      wbm_stb_o  <= 1'b0;
    end else begin
      ch_ready_o <= '0;
      if (state == ARB && found) begin
        ch_ready_o <= 4'b0001 << pick;
        grant      <= pick;
        last_grant <= pick;
        wbm_adr_o  <= aw'(ch_address_i[int'(pick)*dw +: dw]) + aw'({count[pick], 2'b00});
        wbm_dat_o  <= ch_data_i[int'(pick)*dw +: dw];
        wbm_sel_o  <= 4'hF;
        wbm_we_o   <= 1'b1;
        wbm_cyc_o  <= 1'b1;
        wbm_stb_o  <= 1'b1;
      end else if (term) begin
        wbm_sel_o  <= '0;
        wbm_we_o   <= 1'b0;
        wbm_cyc_o  <= 1'b0;
        wbm_stb_o  <= 1'b0;
      end
    end
  end

  // Per-channel status. A disable seen while the channel owns the bus is deferred
  // until the cycle after termination, and that termination leaves status untouched.
  always_ff @(posedge wb_clk) begin
    if (!wb_rst) begin
      for (int n = 0; n < 4; n++) count[n] <= '0;
      full     <= '0;
      wrapped  <= '0;
      error    <= '0;
      clr_pend <= '0;
    end else begin
      for (int n = 0; n < 4; n++) begin
        if (busy[n]) begin
          if (!en[n]) clr_pend[n] <= 1'b1;
          if (term && en[n] && !clr_pend[n]) begin
            if (wbm_err_i) begin
              error[n] <= 1'b1;
            end else if (count_inc[n] == length[n]) begin
              if (wrap[n]) begin
                count[n]   <= '0;
                wrapped[n] <= 1'b1;
              end else begin
                count[n]   <= length[n];
                full[n]    <= 1'b1;
              end
            end else begin
              count[n] <= count_inc[n];
            end
          end
        end else if (!en[n] || clr_pend[n]) begin
          count[n]    <= '0;
          full[n]     <= 1'b0;
          wrapped[n]  <= 1'b0;
          error[n]    <= 1'b0;
          clr_pend[n] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge wb_clk) begin
    if (!wb_rst) interrupt <= 1'b0;
    else         interrupt <= |(irq_en & (full | wrapped | error));
  end

endmodule

// File: tb/tb_wb_daq_channel_arbiter.sv
// Bench for wb_daq_channel_arbiter: sample sources, a Wishbone slave with scripted
// or random wait states, directed vector table, corner sequences and a random run.
module tb_wb_daq_channel_arbiter;
  logic         clk = 1'b0;
  logic         wb_rst;
  logic [31:0]  daq_ctl;
  logic [127:0] ch_adr, ch_ctl, ch_status, ch_data;
  logic [3:0]   ch_valid, ch_ready;
  logic [31:0]  wbm_adr, wbm_dat;
  logic [3:0]   wbm_sel;
  logic         wbm_we, wbm_cyc, wbm_stb;
  logic [2:0]   wbm_cti;
  logic [1:0]   wbm_bte;
  logic         ack_r = 1'b0, err_r = 1'b0;
  logic         irq;

  int tests = 0, fails = 0;
  int cyc_n = 0;

  int          src_idx   [4] = '{default: 0};
  int          src_start [4];
  int          src_cnt   [4];
  logic [31:0] src_data  [4][64];

  logic [31:0] wr_adr[$], wr_dat[$];
  bit          wr_err[$];
  int          wr_len[$];
  int          g_ch[$], g_cyc[$];

  int wr_started = 0, plan_from = 0;
  int plan_wait [8];
  bit plan_err  [8];
  bit slv_rand = 1'b0;
  int wcnt = 0, cur_wait = 0, pk = 0;
  bit cur_err = 1'b0;

  typedef struct {
    int          ch;
    logic [31:0] base;
    int          len;
    bit          wrap;
    bit          irqen;
    int          nsamp;
    logic [31:0] d0;
    int          exp_wr;
    logic [31:0] exp_status;
    bit          exp_irq;
  } vec_t;
  vec_t        vecs [5];
  logic [31:0] vec_adr [5][6];

  bit          ren [4], rwrap [4], rirq [4];
  int          rlen [4], rns [4], kk [4];
  logic [31:0] rbase [4];
  int          g0, w0, acc, tot, ch, ecnt;
  bit          efull, ewrap, eirq;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  for (genvar n = 0; n < 4; n++) begin : g_src
    assign ch_valid[n] = (src_idx[n] - src_start[n]) < src_cnt[n];
    assign ch_data[n*32 +: 32] = src_data[n][6'(src_idx[n] - src_start[n])];
  end

  always @(negedge clk) begin
    for (int n = 0; n < 4; n++)
      if (ch_ready[n] === 1'b1) begin
        src_idx[n] = src_idx[n] + 1;
        g_ch.push_back(n);
        g_cyc.push_back(cyc_n);
      end
  end

  always @(negedge clk) begin
    if (wbm_cyc === 1'b1 && wbm_stb === 1'b1 && !ack_r && !err_r) begin
      if (wcnt == 0) begin
        pk = wr_started - plan_from;
        if (slv_rand) begin
          cur_wait = $urandom_range(0, 2);
          cur_err  = 1'b0;
        end else if (pk >= 0 && pk < 8) begin
          cur_wait = plan_wait[pk];
          cur_err  = plan_err[pk];
        end else begin
          cur_wait = 0;
          cur_err  = 1'b0;
        end
        wr_started = wr_started + 1;
      end
      if (wcnt >= cur_wait) begin
        if (cur_err) err_r = 1'b1;
        else         ack_r = 1'b1;
        wr_adr.push_back(wbm_adr);
        wr_dat.push_back(wbm_dat);
        wr_err.push_back(cur_err);
        wr_len.push_back(wcnt + 1);
      end
      wcnt = wcnt + 1;
    end else begin
      ack_r = 1'b0;
      err_r = 1'b0;
      wcnt  = 0;
    end
  end

  wb_daq_channel_arbiter #(.dw(32), .aw(32)) dut (
    .wb_clk(clk), .wb_rst(wb_rst), .daq_control_reg(daq_ctl),
    .ch_address_i(ch_adr), .ch_control_i(ch_ctl), .ch_status_o(ch_status),
    .ch_valid_i(ch_valid), .ch_data_i(ch_data), .ch_ready_o(ch_ready),
    .wbm_adr_o(wbm_adr), .wbm_dat_o(wbm_dat), .wbm_sel_o(wbm_sel), .wbm_we_o(wbm_we),
    .wbm_cyc_o(wbm_cyc), .wbm_stb_o(wbm_stb), .wbm_cti_o(wbm_cti), .wbm_bte_o(wbm_bte),
    .wbm_ack_i(ack_r), .wbm_err_i(err_r), .interrupt(irq)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic clear_plan();
    plan_from = wr_started;
    for (int k = 0; k < 8; k++) begin
      plan_wait[k] = 0;
      plan_err[k]  = 1'b0;
    end
  endtask

  task automatic do_reset();
    daq_ctl  = '0;
    ch_ctl   = '0;
    ch_adr   = '0;
    slv_rand = 1'b0;
    for (int n = 0; n < 4; n++) src_cnt[n] = 0;
    clear_plan();
    wb_rst = 1'b0;
    tick();
    tick();
    wb_rst = 1'b1;
  endtask

  task automatic set_ch(int n, bit en, bit wrap, bit irqen, int len, logic [31:0] base);
    ch_ctl[n*32 +: 32] = {16'(len), 13'b0, irqen, wrap, en};
    ch_adr[n*32 +: 32] = base;
  endtask

  task automatic load_src(int n, int cnt, logic [31:0] d0, bit rnd);
    src_start[n] = src_idx[n];
    src_cnt[n]   = cnt;
    for (int k = 0; k < 64; k++) src_data[n][k] = rnd ? $urandom : d0 + 32'(k);
  endtask

  function automatic int accepted(int n);
    return src_idx[n] - src_start[n];
  endfunction

  initial begin
    vecs[0] = '{0, 32'h1000, 4, 1'b0, 1'b1, 6, 32'hA0, 4, 32'h0001_0004, 1'b1};
    vecs[1] = '{2, 32'h2000, 3, 1'b1, 1'b1, 5, 32'hB0, 5, 32'h0002_0002, 1'b1};
    vecs[2] = '{3, 32'h3000, 4, 1'b0, 1'b0, 3, 32'hC0, 3, 32'h0000_0003, 1'b0};
    vecs[3] = '{1, 32'h4000, 0, 1'b0, 1'b1, 2, 32'hD0, 0, 32'h0000_0000, 1'b0};
    vecs[4] = '{1, 32'h5000, 2, 1'b0, 1'b0, 4, 32'hE0, 2, 32'h0001_0002, 1'b0};
    vec_adr[0] = '{32'h1000, 32'h1004, 32'h1008, 32'h100C, 32'h0, 32'h0};
    vec_adr[1] = '{32'h2000, 32'h2004, 32'h2008, 32'h2000, 32'h2004, 32'h0};
    vec_adr[2] = '{32'h3000, 32'h3004, 32'h3008, 32'h0, 32'h0, 32'h0};
    vec_adr[3] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    vec_adr[4] = '{32'h5000, 32'h5004, 32'h0, 32'h0, 32'h0, 32'h0};
    for (int n = 0; n < 4; n++) begin
      src_start[n] = 0;
      src_cnt[n]   = 0;
    end

    // Reset state
    do_reset();
    check("rst bus ctl", 32'({wbm_cyc, wbm_stb, wbm_we, wbm_sel, wbm_cti, wbm_bte}), 32'h0);
    check("rst adr", wbm_adr, 32'h0);
    check("rst dat", wbm_dat, 32'h0);
    check("rst ready", 32'(ch_ready), 32'h0);
    check("rst irq", 32'(irq), 32'h0);
    for (int n = 0; n < 4; n++) check($sformatf("rst status%0d", n), ch_status[n*32 +: 32], 32'h0);

    // Single-channel vector table
    for (int v = 0; v < 5; v++) begin
      do_reset();
      set_ch(vecs[v].ch, 1'b1, vecs[v].wrap, vecs[v].irqen, vecs[v].len, vecs[v].base);
      load_src(vecs[v].ch, vecs[v].nsamp, vecs[v].d0, 1'b0);
      w0 = wr_adr.size();
      daq_ctl = 32'h1;
      repeat (40) tick();
      check($sformatf("v%0d writes", v), 32'(wr_adr.size() - w0), 32'(vecs[v].exp_wr));
      for (int k = 0; k < vecs[v].exp_wr && w0 + k < wr_adr.size(); k++) begin
        check($sformatf("v%0d adr%0d", v, k), wr_adr[w0+k], vec_adr[v][k]);
        check($sformatf("v%0d dat%0d", v, k), wr_dat[w0+k], vecs[v].d0 + 32'(k));
      end
      check($sformatf("v%0d status", v), ch_status[vecs[v].ch*32 +: 32], vecs[v].exp_status);
      check($sformatf("v%0d irq", v), 32'(irq), 32'(vecs[v].exp_irq));
      check($sformatf("v%0d accepted", v), 32'(accepted(vecs[v].ch)), 32'(vecs[v].exp_wr));
    end

    // Round robin with four continuously valid channels
    do_reset();
    for (int n = 0; n < 4; n++) begin
      set_ch(n, 1'b1, 1'b0, 1'b0, 8, 32'h100 * (n + 1));
      load_src(n, 100, 32'h10 * n, 1'b0);
    end
    g0 = g_ch.size();
    daq_ctl = 32'h1;
    for (int i = 0; i < 200 && g_ch.size() - g0 < 32; i++) tick();
    check("rr grant count", 32'(g_ch.size() - g0 >= 32), 32'h1);
    for (int i = 0; i < 16 && g0 + i < g_ch.size(); i++) begin
      check($sformatf("rr order%0d", i), 32'(g_ch[g0+i]), 32'(i % 4));
      if (i > 0) check($sformatf("rr gap%0d", i), 32'(g_cyc[g0+i] - g_cyc[g0+i-1]), 32'd2);
    end
    repeat (10) tick();
    for (int n = 0; n < 4; n++) check($sformatf("rr status%0d", n), ch_status[n*32 +: 32], 32'h0001_0008);

    // Wait states on the first write, bus error on the second
    do_reset();
    set_ch(0, 1'b1, 1'b0, 1'b1, 4, 32'h1000);
    load_src(0, 6, 32'hA0, 1'b0);
    plan_wait[0] = 3;
    plan_err[1]  = 1'b1;
    w0 = wr_adr.size();
    daq_ctl = 32'h1;
    for (int i = 0; i < 10 && ch_ready[0] !== 1'b1; i++) tick();
    check("ws grant seen", 32'(ch_ready[0]), 32'h1);
    check("ws busy", 32'(ch_status[19]), 32'h1);
    for (int c = 0; c < 4; c++) begin
      check($sformatf("ws hold ctl c%0d", c), 32'({wbm_cyc, wbm_stb, wbm_we, wbm_sel}), 32'h7F);
      check($sformatf("ws hold adr c%0d", c), wbm_adr, 32'h1000);
      check($sformatf("ws hold dat c%0d", c), wbm_dat, 32'hA0);
      tick();
    end
    repeat (20) tick();
    check("ws writes", 32'(wr_adr.size() - w0), 32'd2);
    if (wr_adr.size() - w0 >= 2) begin
      check("ws stall length", 32'(wr_len[w0]), 32'd4);
      check("ws first ok", 32'(wr_err[w0]), 32'h0);
      check("ws second err", 32'(wr_err[w0+1]), 32'h1);
      check("ws second adr", wr_adr[w0+1], 32'h1004);
    end
    check("ws status", ch_status[31:0], 32'h0004_0001);
    check("ws accepted", 32'(accepted(0)), 32'd2);
    check("ws irq", 32'(irq), 32'h1);
    set_ch(0, 1'b0, 1'b0, 1'b1, 4, 32'h1000);
    repeat (3) tick();
    check("clr status", ch_status[31:0], 32'h0);
    check("clr irq", 32'(irq), 32'h0);

    // Reset while a write is stalled
    do_reset();
    set_ch(0, 1'b1, 1'b0, 1'b0, 4, 32'h1000);
    set_ch(1, 1'b1, 1'b0, 1'b0, 4, 32'h2000);
    load_src(0, 4, 32'h50, 1'b0);
    load_src(1, 4, 32'h60, 1'b0);
    plan_wait[1] = 30;
    g0 = g_ch.size();
    daq_ctl = 32'h1;
    for (int i = 0; i < 20 && g_ch.size() - g0 < 2; i++) tick();
    check("rmw two grants", 32'(g_ch.size() - g0 >= 2), 32'h1);
    if (g_ch.size() - g0 >= 2) check("rmw stalled ch", 32'(g_ch[g0+1]), 32'd1);
    tick();
    wb_rst = 1'b0;
    tick();
    check("rmw cyc stb", 32'({wbm_cyc, wbm_stb}), 32'h0);
    check("rmw ready", 32'(ch_ready), 32'h0);
    for (int n = 0; n < 4; n++) check($sformatf("rmw status%0d", n), ch_status[n*32 +: 32], 32'h0);
    wb_rst = 1'b1;
    g0 = g_ch.size();
    for (int i = 0; i < 10 && g_ch.size() == g0; i++) tick();
    check("rmw regrant", 32'(g_ch.size() > g0), 32'h1);
    if (g_ch.size() > g0) check("rmw first ch", 32'(g_ch[g0]), 32'd0);

    // Global disable while a write waits for ack
    do_reset();
    set_ch(0, 1'b1, 1'b0, 1'b0, 4, 32'h1000);
    load_src(0, 4, 32'h70, 1'b0);
    plan_wait[0] = 2;
    w0 = wr_adr.size();
    daq_ctl = 32'h1;
    for (int i = 0; i < 10 && ch_ready[0] !== 1'b1; i++) tick();
    check("dis grant seen", 32'(ch_ready[0]), 32'h1);
    daq_ctl = 32'h0;
    repeat (20) tick();
    check("dis writes", 32'(wr_adr.size() - w0), 32'd1);
    if (wr_adr.size() > w0) check("dis stall length", 32'(wr_len[w0]), 32'd3);
    check("dis accepted", 32'(accepted(0)), 32'd1);
    check("dis status", ch_status[31:0], 32'h0000_0001);
    check("dis cyc", 32'(wbm_cyc), 32'h0);

    // Random configurations against the per-channel buffer model
    for (int it = 0; it < 4; it++) begin
      do_reset();
      slv_rand = 1'b1;
      for (int n = 0; n < 4; n++) begin
        ren[n]   = ($urandom_range(0, 3) != 0);
        rwrap[n] = 1'($urandom_range(0, 1));
        rirq[n]  = 1'($urandom_range(0, 1));
        rlen[n]  = $urandom_range(0, 6);
        rns[n]   = $urandom_range(0, 10);
        rbase[n] = 32'((n + 1) * 4096 + 4 * $urandom_range(0, 63));
        set_ch(n, ren[n], rwrap[n], rirq[n], rlen[n], rbase[n]);
        load_src(n, rns[n], 32'h0, 1'b1);
        kk[n] = 0;
      end
      g0 = g_ch.size();
      w0 = wr_adr.size();
      daq_ctl = 32'h1;
      repeat (300) tick();
      tot  = 0;
      eirq = 1'b0;
      for (int n = 0; n < 4; n++) begin
        if (!ren[n] || rlen[n] == 0) acc = 0;
        else if (rwrap[n])           acc = rns[n];
        else                         acc = (rns[n] < rlen[n]) ? rns[n] : rlen[n];
        tot   = tot + acc;
        ecnt  = 0;
        efull = 1'b0;
        ewrap = 1'b0;
        if (acc > 0) begin
          if (rwrap[n]) begin
            ecnt  = acc % rlen[n];
            ewrap = (acc >= rlen[n]);
          end else begin
            ecnt  = acc;
            efull = (acc == rlen[n]);
          end
        end
        eirq = eirq | (rirq[n] & (efull | ewrap));
        check($sformatf("rnd%0d accepted%0d", it, n), 32'(accepted(n)), 32'(acc));
        check($sformatf("rnd%0d status%0d", it, n), ch_status[n*32 +: 32],
              {14'b0, ewrap, efull, 16'(ecnt)});
      end
      check($sformatf("rnd%0d irq", it), 32'(irq), 32'(eirq));
      check($sformatf("rnd%0d writes", it), 32'(wr_adr.size() - w0), 32'(tot));
      check($sformatf("rnd%0d grants", it), 32'(g_ch.size() - g0), 32'(tot));
      for (int i = 0; i < tot && w0 + i < wr_adr.size() && g0 + i < g_ch.size(); i++) begin
        ch = g_ch[g0+i];
        if (rlen[ch] > 0) begin
          check($sformatf("rnd%0d adr%0d", it, i), wr_adr[w0+i],
                rbase[ch] + 32'(4 * (kk[ch] % rlen[ch])));
          check($sformatf("rnd%0d dat%0d", it, i), wr_dat[w0+i], src_data[ch][kk[ch] % 64]);
        end
        kk[ch] = kk[ch] + 1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wb_daq_channel_arbiter.md
# wb_daq_channel_arbiter

Round-robin scheduler that moves samples from the four DAQ acquisition channels into system memory over a Wishbone B3 master port. It sits between the channel sample sources and the memory interconnect. It consumes the configuration registers written through the DAQ slave register block and returns per-channel status words and an interrupt to that block. One sample is accepted from one channel at a time, written as a single 32-bit classic-cycle store to that channel's buffer, and the channel's buffer pointer is advanced.

## Interface
- `dw`, 32: data width; only 32 is supported.
- `aw`, 32: master address width.
- `wb_clk` in 1: sole clock.
- `wb_rst` in 1: reset, synchronous, active-low (0 = reset).
- `daq_control_reg` in dw: global control; bit0 is `daq_en`.
- `ch_address_i` in 4*dw: per-channel buffer base byte addresses, word-aligned. Channel n occupies `[n*dw +: dw]`.
- `ch_control_i` in 4*dw: per-channel control. Bit0 is `en`, bit1 is `wrap`, bit2 is `irq_en`, bits[31:16] are `length` (buffer size in words).
- `ch_status_o` out 4*dw: per-channel status. Bits[15:0] are `count`, bit16 `full`, bit17 `wrapped`, bit18 `error`, bit19 `busy`; all other bits are 0.
- `ch_valid_i` in 4: channel n has a sample pending.
- `ch_data_i` in 4*dw: sample data, held stable while valid.
- `ch_ready_o` out 4: one-cycle accept strobe to channel n.
- `wbm_adr_o` out aw, `wbm_dat_o` out dw, `wbm_sel_o` out 4, `wbm_we_o` out 1, `wbm_cyc_o` out 1, `wbm_stb_o` out 1, `wbm_cti_o` out 3, `wbm_bte_o` out 2: Wishbone master outputs.
- `wbm_ack_i` in 1, `wbm_err_i` in 1: Wishbone master responses.
- `interrupt` out 1: level interrupt.

## Operation
**Eligibility.** Channel n is eligible when all of the following hold:
- `daq_en` = 1, `en` = 1, `ch_valid_i[n]` = 1;
- `full` = 0 and `error` = 0;
- `length` != 0.

**State machine:** IDLE, ARB, WRITE.
- **IDLE:** go to ARB when `daq_en` = 1.
- **ARB:**
  - If any channel is eligible, grant the first eligible channel searching from `(last_grant+1) mod 4`.
  - On a grant: pulse `ch_ready_o[g]`, latch `ch_data_i[g]` and the address, record `last_grant = g`, go to WRITE.
  - If no channel is eligible: stay in ARB while `daq_en` = 1; otherwise go to IDLE.
- **WRITE:**
  - Drive `cyc` = `stb` = `we` = 1, `sel` = 4'hF, `cti` = 3'b000, `bte` = 2'b00.
  - `adr` = `base[g] + (count[g] << 2)`, truncated to aw. `dat` = the latched sample.
  - Hold these outputs until `ack` or `err`.
- **On ack:**
  - `count` increments.
  - If the new count equals `length`: with `wrap` = 1, set `count` = 0 and `wrapped` = 1; with `wrap` = 0, set `full` = 1 and `count` = `length`.
  - Return to ARB.
- **On err:** set `error` = 1. The sample is dropped and `count` is unchanged. Return to ARB.
- **ack and err in the same cycle:** err wins.
- **`busy[n]`:** 1 while channel n is granted in WRITE.
- **Clearing status:** `en[n]` = 0 clears `count`, `full`, `wrapped` and `error` for channel n, unless n is currently in WRITE. In that case the clear happens in the cycle after the cycle terminates; the in-flight write still completes and its ack does not update status.
- **`daq_en` dropped mid-WRITE:** the cycle completes normally, then the block returns to IDLE via ARB.
- **`interrupt`:** registered OR over n of `irq_en[n]` & (`full[n]` | `wrapped[n]` | `error[n]`). It clears only by clearing the source bits.

## Timing
- **Reset values** (`wb_rst` = 0 at a clock edge):
  - state = IDLE, `last_grant` = 3 (so channel 0 wins first);
  - all `count` and status bits = 0;
  - `ch_ready_o` = 0, `interrupt` = 0;
  - all wbm outputs = 0.
- Reset overrides an in-flight cycle: `cyc` and `stb` drop at that edge.
- `ch_ready_o` is a registered pulse, high exactly one cycle, concurrent with the ARB→WRITE transition edge. `wbm_stb_o` rises in the first WRITE cycle.
- With a zero-wait slave (ack in the first WRITE cycle), throughput is one sample per 2 clocks.
- Status updates are visible on `ch_status_o` the cycle after the ack edge. `interrupt` follows one cycle after that.
- Wait states: the master outputs are stable for every stalled cycle.

## Test plan
- **Single channel, zero-wait.** Reset, then `daq_en` = 1, ch0 `en` = 1, `length` = 4, base 0x1000, ch0 streams 0xA0..0xA5. Expect 4 writes at 0x1000, 0x1004, 0x1008, 0x100C with data 0xA0..0xA3. Then `full` = 1, `count` = 4, no further `ch_ready_o[0]`, and `interrupt` = 1 if `irq_en` = 1.
- **Round robin.** All four channels valid continuously, each with `length` = 8. Expect grant order 0,1,2,3,0,1,… and 2 clocks per grant.
- **Wrap.** ch2 with `wrap` = 1, `length` = 3, base 0x2000, 5 samples. Expect addresses 0x2000, 0x2004, 0x2008, 0x2000, 0x2004. Expect `wrapped` = 1, `count` = 2, `full` = 0.
- **Wait states and err.** Slave inserts 3 wait cycles on the first write: expect outputs held 4 cycles. Slave asserts err on the second write: expect `error` = 1, `count` = 1, and the channel no longer granted. Clearing `en` clears status and `interrupt`.
- **Reset mid-write.** Assert `wb_rst` = 0 during a stalled WRITE. Expect `cyc`/`stb` = 0 the next cycle and all status = 0. After release, the first grant goes to ch0.
- **Disable mid-write.** Drop `daq_en` during WRITE with ack after 2 cycles. Expect the write to complete, then IDLE, and no further `ch_ready_o`.
